// File: rtl/data_mem_responder_if.sv
// CPU load/store bus between the CPU (master) and the data memory (slave).
// Data_Bus is a shared tri-state net. The CPU drives it for stores and the memory drives it for load data.
interface data_mem_responder_if;
  logic [31:0] ADDR;
  logic        WE;
  logic        CS;
  wire  [31:0] Data_Bus;
  logic        READY;
  logic        ERR;

  modport master (output ADDR, output WE, output CS, inout Data_Bus, input READY, input ERR);
  modport slave  (input ADDR, input WE, input CS, inout Data_Bus, output READY, output ERR);
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering the CPU load/store bus with configurable read latency.
// Misaligned or out-of-range accesses raise ERR and return 32'hDEAD_BEEF on loads.
module data_mem_responder #(
    parameter int          ADDR_WIDTH   = 8,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                    CLK,
    input  logic                    RST,
    data_mem_responder_if.slave     bus,
    output logic [1:0]              dbg_state,
    output logic                    dbg_bus_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 2);
    localparam logic [32:0] ADDR_END  = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);

    logic [31:0]           mem [2**ADDR_WIDTH];
    state_t                state;
    logic [1:0]            cnt;
    logic [31:0]           rdata;
    logic                  rd_bad;
    logic                  ready_q;
    logic                  err_q;

    logic                  req_bad;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  store_fire;
    logic                  bus_oe;

    // ADDR_END is 33 bits wide, so a window that ends at the 4 GiB boundary is still compared correctly.
    assign req_bad = (bus.ADDR[1:0] != 2'b00) || (bus.ADDR < BASE_ADDR) ||
                     ({1'b0, bus.ADDR} >= ADDR_END);
    assign req_idx = ADDR_WIDTH'((bus.ADDR - BASE_ADDR) >> 2);

    assign store_fire = RST && bus.CS && bus.WE && !req_bad &&
                        ((state == IDLE) || (state == DRIVE));

    // The bus drive is gated combinationally, so a WE flip by the CPU releases the bus in the same cycle.
    assign bus_oe       = (state == DRIVE) && bus.CS && !bus.WE;
    assign bus.Data_Bus = bus_oe ? rdata : 32'bz;

    assign bus.READY  = ready_q;
    assign bus.ERR    = err_q;
    assign dbg_state  = state;
    assign dbg_bus_oe = bus_oe;

    // Reset does not clear the storage. Only the control state is cleared.
    always_ff @(posedge CLK) begin
        if (store_fire) begin
            mem[req_idx] <= bus.Data_Bus;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            rdata   <= 32'd0;
            rd_bad  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CS && bus.WE) begin
                        ready_q <= 1'b1;
                        err_q   <= req_bad;
                    end else if (bus.CS) begin
                        rdata  <= req_bad ? 32'hDEAD_BEEF : mem[req_idx];
                        rd_bad <= req_bad;
                        if (READ_LATENCY == 1) begin
                            state   <= DRIVE;
                            ready_q <= 1'b1;
                            err_q   <= req_bad;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.CS) begin
                        state <= IDLE;
                    end else if (cnt == 2'd0) begin
                        state   <= DRIVE;
                        ready_q <= 1'b1;
                        err_q   <= rd_bad;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DRIVE: begin
                    if (!bus.CS) begin
                        state <= IDLE;
                    end else if (bus.WE) begin
                        // A store issued while data is held on the bus is accepted, and the FSM then leaves DRIVE.
                        state   <= IDLE;
                        ready_q <= 1'b1;
                        err_q   <= req_bad;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: runs two responders (read latency 1 and 3) side by side on one shared CPU stimulus.
module tb_data_mem_responder;

    logic        CLK;
    logic        RST;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic        tb_drv;
    logic [31:0] tb_data;
    int          checks;
    int          failures;

    logic [1:0]  st1, st3;
    logic        oe1, oe3;

    data_mem_responder_if if1 ();
    data_mem_responder_if if3 ();

    assign if1.ADDR = addr;
    assign if1.WE   = we;
    assign if1.CS   = cs;
    assign if1.Data_Bus = tb_drv ? tb_data : 32'bz;
    assign if3.ADDR = addr;
    assign if3.WE   = we;
    assign if3.CS   = cs;
    assign if3.Data_Bus = tb_drv ? tb_data : 32'bz;

    data_mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
        .CLK(CLK), .RST(RST), .bus(if1), .dbg_state(st1), .dbg_bus_oe(oe1)
    );
    data_mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(3), .BASE_ADDR(32'h0)) dut3 (
        .CLK(CLK), .RST(RST), .bus(if3), .dbg_state(st3), .dbg_bus_oe(oe3)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic set_in(input logic c, input logic w, input logic [31:0] a,
                          input logic d, input logic [31:0] v);
        cs = c; we = w; addr = a; tb_drv = d; tb_data = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RST = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick(); tick();
        chk("rst_ready1", {31'd0, if1.READY}, 32'd0);
        chk("rst_err1",   {31'd0, if1.ERR},   32'd0);
        chk("rst_oe1",    {31'd0, oe1},       32'd0);
        chk("rst_ready3", {31'd0, if3.READY}, 32'd0);
        chk("rst_oe3",    {31'd0, oe3},       32'd0);

        // Seed word 0 so the discarded store during reset can be told apart
        RST = 1'b1;
        set_in(1'b1, 1'b1, 32'h0, 1'b1, 32'h2222_2222);
        tick();
        chk("seed_ready1", {31'd0, if1.READY}, 32'd1);
        chk("seed_err1",   {31'd0, if1.ERR},   32'd0);

        RST = 1'b0;
        set_in(1'b1, 1'b1, 32'h0, 1'b1, 32'h1111_1111);
        tick(); tick();
        chk("rst_st_ready1", {31'd0, if1.READY}, 32'd0);
        chk("rst_st_err1",   {31'd0, if1.ERR},   32'd0);
        chk("rst_st_ready3", {31'd0, if3.READY}, 32'd0);
        chk("rst_st_oe1",    {31'd0, oe1},       32'd0);
        RST = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        set_in(1'b1, 1'b1, 32'h10, 1'b1, 32'hCAFE_0001);
        tick();
        chk("st10_ready1", {31'd0, if1.READY}, 32'd1);
        chk("st10_ready3", {31'd0, if3.READY}, 32'd1);
        chk("st10_err1",   {31'd0, if1.ERR},   32'd0);

        set_in(1'b1, 1'b1, 32'h13, 1'b1, 32'hBAD0_BAD0);
        tick();
        chk("st13_ready1", {31'd0, if1.READY}, 32'd1);
        chk("st13_err1",   {31'd0, if1.ERR},   32'd1);
        chk("st13_err3",   {31'd0, if3.ERR},   32'd1);

        set_in(1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
        tick();
        chk("ld10_ready1", {31'd0, if1.READY}, 32'd1);
        chk("ld10_err1",   {31'd0, if1.ERR},   32'd0);
        chk("ld10_oe1",    {31'd0, oe1},       32'd1);
        chk("ld10_bus1",   if1.Data_Bus,       32'hCAFE_0001);
        chk("ld10_ready3_c1", {31'd0, if3.READY}, 32'd0);
        chk("ld10_oe3_c1",    {31'd0, oe3},       32'd0);
        tick();
        chk("ld10_ready1_c2", {31'd0, if1.READY}, 32'd0);
        chk("ld10_bus1_c2",   if1.Data_Bus,       32'hCAFE_0001);
        chk("ld10_oe3_c2",    {31'd0, oe3},       32'd0);
        tick();
        chk("ld10_ready3", {31'd0, if3.READY}, 32'd1);
        chk("ld10_err3",   {31'd0, if3.ERR},   32'd0);
        chk("ld10_oe3",    {31'd0, oe3},       32'd1);
        chk("ld10_bus3",   if3.Data_Bus,       32'hCAFE_0001);
        chk("ld10_ready1_c3", {31'd0, if1.READY}, 32'd0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("ld10_rel_oe1", {31'd0, oe1}, 32'd0);
        chk("ld10_rel_oe3", {31'd0, oe3}, 32'd0);
        tick();

        // Load word 0 for one edge: latency 1 returns the seed, and latency 3 is cancelled in WAIT
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("ld0_bus1",   if1.Data_Bus,       32'h2222_2222);
        chk("ld0_ready1", {31'd0, if1.READY}, 32'd1);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        chk("cancel_ready3_c1", {31'd0, if3.READY}, 32'd0);
        chk("cancel_oe3_c1",    {31'd0, oe3},       32'd0);
        tick();
        chk("cancel_ready3_c2", {31'd0, if3.READY}, 32'd0);
        chk("cancel_oe3_c2",    {31'd0, oe3},       32'd0);
        tick();
        chk("cancel_ready3_c3", {31'd0, if3.READY}, 32'd0);

        set_in(1'b1, 1'b0, 32'h400, 1'b0, 32'h0);
        tick();
        chk("oor_bus1",   if1.Data_Bus,       32'hDEAD_BEEF);
        chk("oor_ready1", {31'd0, if1.READY}, 32'd1);
        chk("oor_err1",   {31'd0, if1.ERR},   32'd1);
        tick(); tick();
        chk("oor_bus3",   if3.Data_Bus,       32'hDEAD_BEEF);
        chk("oor_ready3", {31'd0, if3.READY}, 32'd1);
        chk("oor_err3",   {31'd0, if3.ERR},   32'd1);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        set_in(1'b1, 1'b1, 32'h20, 1'b1, 32'hA5A5_A5A5);
        tick();
        chk("st20_ready1", {31'd0, if1.READY}, 32'd1);
        set_in(1'b1, 1'b0, 32'h20, 1'b0, 32'h0);
        tick();
        chk("b2b_bus1",   if1.Data_Bus,       32'hA5A5_A5A5);
        chk("b2b_ready1", {31'd0, if1.READY}, 32'd1);
        tick(); tick();
        chk("b2b_bus3",   if3.Data_Bus,       32'hA5A5_A5A5);
        chk("b2b_ready3", {31'd0, if3.READY}, 32'd1);

        // Store issued while both responders sit in DRIVE
        set_in(1'b1, 1'b1, 32'h24, 1'b1, 32'h1234_5678);
        tick();
        chk("drv_st_ready1", {31'd0, if1.READY}, 32'd1);
        chk("drv_st_ready3", {31'd0, if3.READY}, 32'd1);
        chk("drv_st_err1",   {31'd0, if1.ERR},   32'd0);
        set_in(1'b1, 1'b0, 32'h24, 1'b0, 32'h0);
        tick();
        chk("ld24_bus1",   if1.Data_Bus,       32'h1234_5678);
        chk("ld24_ready1", {31'd0, if1.READY}, 32'd1);
        tick(); tick();
        chk("ld24_bus3",   if3.Data_Bus,       32'h1234_5678);
        chk("ld24_ready3", {31'd0, if3.READY}, 32'd1);

        we = 1'b1;
        #1;
        chk("weflip_oe1", {31'd0, oe1}, 32'd0);
        chk("weflip_oe3", {31'd0, oe3}, 32'd0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        set_in(1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
        tick();
        chk("mid_oe1", {31'd0, oe1}, 32'd1);
        RST = 1'b0;
        tick();
        chk("mid_rst_oe1",    {31'd0, oe1},       32'd0);
        chk("mid_rst_ready1", {31'd0, if1.READY}, 32'd0);
        chk("mid_rst_ready3", {31'd0, if3.READY}, 32'd0);
        chk("mid_rst_oe3",    {31'd0, oe3},       32'd0);
        RST = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-addressed data memory that answers the CPU's load/store bus as the responding end: it samples ADDR/WE/CS from the CPU, commits stores into internal storage, and drives the shared 32-bit Data_Bus with load data after a configurable latency. Sits beside the CPU on the same clock and is the only device other than the CPU allowed to drive Data_Bus. Misaligned or out-of-range accesses are flagged rather than silently aliased.

## Interface
- ADDR_WIDTH, 8, log2 of word count (storage = 2^ADDR_WIDTH x 32 bits)
- READ_LATENCY, 1, cycles from sampled read request to first data cycle on bus; legal 1..4
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-low (RST==0 at a rising edge resets)
- ADDR  in  32  byte address from CPU
- WE  in  1  1 = store, 0 = load; qualified by CS
- CS  in  1  chip select; request valid when 1
- Data_Bus  inout  32  store data in; load data out; high-Z when not driving
- READY  out  1  one-cycle pulse: load data valid this cycle, or store committed last edge
- ERR  out  1  one-cycle pulse coincident with READY when the access was misaligned or out of range

## Operation
- States: IDLE, WAIT, DRIVE.
- Word index = (ADDR - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits. Access is bad if ADDR[1:0] != 0 or ADDR < BASE_ADDR or ADDR >= BASE_ADDR + 4*2^ADDR_WIDTH.
- IDLE, CS=1, WE=1 at edge: if good, mem[index] <= Data_Bus; stay IDLE; READY=1 next cycle. If bad, no write; READY=1 and ERR=1 next cycle.
- IDLE, CS=1, WE=0 at edge: latch index and bad flag; rdata <= bad ? 32'hDEAD_BEEF : mem[index]. READ_LATENCY==1 -> DRIVE; else -> WAIT with counter = READ_LATENCY-2.
- WAIT: counter decrements each edge; at 0 -> DRIVE. If CS==0 at any WAIT edge -> IDLE, no drive, no READY.
- DRIVE: Data_Bus = rdata while state==DRIVE and CS==1 and WE==0 (combinational gate; releases immediately if CPU flips WE). READY (and ERR if bad) high only in first DRIVE cycle. Stays in DRIVE holding rdata while CS==1, WE==0; ADDR changes ignored. CS==0 at edge -> IDLE. CS==1, WE==1 at edge -> treated as a new store exactly as in IDLE, next state IDLE.
- A new load requires a return to IDLE (CS low for at least one edge) after DRIVE.
- Memory contents are not affected by reset; power-up contents undefined.

## Timing
- Reset (RST==0 at edge): state IDLE, counter 0, rdata 0, READY 0, ERR 0, Data_Bus high-Z from the next cycle. RST wins over any simultaneous request; a store sampled on a reset edge is discarded.
- Reset mid-WAIT/DRIVE: bus released next cycle, no READY.
- Load latency: request sampled at edge N -> data on bus and READY in cycle N+READY_LATENCY (i.e., between edges N+READ_LATENCY-... precisely: READ_LATENCY=1 gives data in cycle directly after edge N).
- Store: committed at sampling edge; read of same word issued at the next edge returns new data.
- Data_Bus never driven in IDLE or WAIT; no bus contention with the CPU in any state.
- READY/ERR are registered outputs, never high for more than one consecutive cycle per access.

## Test plan
- Reset: hold RST=0 two edges with CS=1, WE=1, ADDR=0, bus=32'h1111_1111 -> READY=0, ERR=0, bus Z; later read of addr 0 does not return 32'h1111_1111 from that attempt.
- Store/load, latency 1: store 32'hCAFE_0001 at 0x10, then load 0x10 with CS held two cycles -> bus=32'hCAFE_0001 and READY=1 in cycle after load request edge; bus Z after CS drops.
- Latency 3: READ_LATENCY=3, load 0x10 -> bus Z for two cycles, then 32'hCAFE_0001 with READY; CS dropped during WAIT in a second load -> no READY, bus stays Z.
- Misaligned/out-of-range: store to 0x13 -> READY=1, ERR=1, word 0x10 unchanged; load 0x400 (ADDR_WIDTH=8) -> bus=32'hDEAD_BEEF, READY=1, ERR=1.
- Back-to-back: store 32'hA5A5_A5A5 to 0x20 at edge N, load 0x20 at edge N+1 -> returns 32'hA5A5_A5A5; store issued from DRIVE commits and returns to IDLE.
- WE flip in DRIVE: CS=1, WE toggles 0->1 mid-cycle -> Data_Bus released to Z combinationally in that cycle.
